// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch stage and the decode side of the pipeline.
package pipe_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // addi x0,x0,0 -- the bubble placed in IF/ID.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default PC after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // IF/ID pipeline register contents, also consumed by decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats write-enable, write-enable beats load.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output if_id_t      q
);

  // Register update: reset/flush clear to a bubble, a held register keeps
  // everything, an empty slot becomes a bubble but keeps the last pc.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q.instr <= BUBBLE_INSTR;
      q.pc    <= '0;
      q.valid <= 1'b0;
    end else if (write_en) begin
      if (load) begin
        q.instr <= load_instr;
        q.pc    <= load_pc;
        q.valid <= 1'b1;
      end else begin
        q.instr <= BUBBLE_INSTR;
        q.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding-request
// memory handshake, buffers a response while decode is stalled, and feeds IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  pipe_pkg::fetch_state_t state_reg, state_next;
  logic [31:0]            pc_reg, pc_next;
  logic [31:0]            skid_reg, skid_next;
  logic [31:0]            redirect_aligned;
  logic                   advance;
  logic                   deliver;
  logic [31:0]            deliver_instr;
  pipe_pkg::if_id_t       if_id;

  // A mismatched stall pair is treated as a stall.
  assign advance          = pc_write & if_id_write;
  assign redirect_aligned = redirect_pc & ~32'h3;
  assign imem_addr        = pc_reg;

  // Next-state, PC, skid buffer and delivery decode. A request that is being
  // redirected this cycle is withdrawn so memory never accepts a fetch the
  // controller is about to abandon.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    skid_next     = skid_reg;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    imem_req      = 1'b0;
    case (state_reg)
      pipe_pkg::REQ: begin
        imem_req = ~flush & ~rst;
        if (flush) begin
          pc_next = redirect_aligned;
        end else if (imem_gnt) begin
          state_next = pipe_pkg::WAIT;
        end
      end
      pipe_pkg::WAIT: begin
        if (flush) begin
          pc_next    = redirect_aligned;
          state_next = imem_rvalid ? pipe_pkg::REQ : pipe_pkg::DRAIN;
        end else if (imem_rvalid) begin
          if (advance) begin
            deliver    = 1'b1;
            pc_next    = pc_reg + 32'd4;
            state_next = pipe_pkg::REQ;
          end else begin
            skid_next  = imem_rdata;
            state_next = pipe_pkg::HOLD;
          end
        end
      end
      pipe_pkg::HOLD: begin
        if (flush) begin
          pc_next    = redirect_aligned;
          state_next = pipe_pkg::REQ;
        end else if (advance) begin
          deliver       = 1'b1;
          deliver_instr = skid_reg;
          pc_next       = pc_reg + 32'd4;
          state_next    = pipe_pkg::REQ;
        end
      end
      pipe_pkg::DRAIN: begin
        if (flush) begin
          pc_next = redirect_aligned;
        end
        if (imem_rvalid) begin
          state_next = pipe_pkg::REQ;
        end
      end
      default: begin
        state_next = pipe_pkg::REQ;
      end
    endcase
  end

  // State, PC and skid buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= pipe_pkg::REQ;
      pc_reg    <= RESET_PC;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      skid_reg  <= skid_next;
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .write_en  (if_id_write),
    .load      (deliver),
    .load_instr(deliver_instr),
    .load_pc   (pc_reg),
    .q         (if_id)
  );

  assign if_id_instr = if_id.instr;
  assign if_id_pc    = if_id.pc;
  assign if_id_valid = if_id.valid;

  // The hazard unit must drive both stall enables together.
  stall_pair_legal: assert property (@(posedge clk) disable iff (rst)
    (pc_write == if_id_write));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner-case sequences
// and randomized traffic against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc_write   (pc_write),
    .if_id_write(if_id_write),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_valid(if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: deterministic function of the word address.
  function automatic logic [31:0] img(input logic [31:0] addr);
    return {addr[31:2] ^ 30'h2AAA_5555, 2'b11};
  endfunction

  // Memory model state.
  logic        mem_pending;
  int          mem_wait;
  logic [31:0] mem_addr;

  // Reference model: program PC, one fetch in flight (possibly stale after a
  // redirect), at most one fetched-but-undelivered instruction, IF/ID contents.
  logic [31:0] m_pc;
  logic        m_inflight;
  logic        m_stale;
  logic        m_held;
  logic [31:0] m_held_instr;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_valid;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mem_pending = 1'b0;
    mem_wait    = 0;
    mem_addr    = '0;
    m_pc        = 32'h0;
    m_inflight  = 1'b0;
    m_stale     = 1'b0;
    m_held      = 1'b0;
    m_held_instr = '0;
    m_instr     = NOP;
    m_ifpc      = '0;
    m_valid     = 1'b0;
  endtask

  task automatic check_model(input string name);
    logic        er;
    logic [97:0] act, exp;
    er  = !m_inflight && !m_held;
    exp = {er, er ? m_pc : 32'h0, m_instr, m_ifpc, m_valid};
    act = {imem_req, imem_req ? imem_addr : 32'h0, if_id_instr, if_id_pc, if_id_valid};
    chk(name, {30'h0, act}, {30'h0, exp});
  endtask

  // One clock cycle: drive inputs, advance memory and reference model, compare.
  task automatic step(input logic fl, input logic [31:0] rp, input logic adv,
                      input logic g, input int lat);
    logic        rv, acc, er, resp_ok, dlv;
    logic [31:0] rd, d_instr, d_pc;
    er = !m_inflight && !m_held;
    rv = mem_pending && (mem_wait == 0);
    rd = rv ? img(mem_addr) : $urandom;
    flush = fl; redirect_pc = rp; pc_write = adv; if_id_write = adv;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    acc = er && !fl && g;
    #1;
    chk("req_while_driving", {127'h0, imem_req}, {127'h0, er && !fl});
    @(posedge clk);
    #1;
    if (rv) mem_pending = 1'b0;
    else if (mem_pending) mem_wait--;
    if (acc) begin
      mem_pending = 1'b1;
      mem_wait    = lat - 1;
      mem_addr    = m_pc;
    end
    resp_ok = 1'b0;
    if (rv) begin
      resp_ok    = m_inflight && !m_stale;
      m_inflight = 1'b0;
      m_stale    = 1'b0;
    end
    if (fl) begin
      m_pc    = rp & ~32'h3;
      m_held  = 1'b0;
      if (m_inflight) m_stale = 1'b1;
      m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
    end else begin
      dlv = 1'b0; d_instr = '0; d_pc = '0;
      if (resp_ok) begin
        m_held = 1'b1;
        m_held_instr = rd;
      end
      if (m_held && adv) begin
        dlv = 1'b1; d_instr = m_held_instr; d_pc = m_pc;
        m_pc = m_pc + 32'd4;
        m_held = 1'b0;
      end
      if (acc) m_inflight = 1'b1;
      if (adv) begin
        if (dlv) begin
          m_instr = d_instr; m_ifpc = d_pc; m_valid = 1'b1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
    end
    flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    check_model("model");
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; redirect_pc = '0;
    #1;
    chk("req_during_rst", {127'h0, imem_req}, 128'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ifid", {63'h0, if_id_instr, if_id_pc, if_id_valid}, {63'h0, NOP, 32'h0, 1'b0});
    chk("req_during_rst2", {127'h0, imem_req}, 128'h0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req_addr", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'h0});
    check_model("rst_model");
  endtask

  typedef struct {
    logic        adv;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h4,  32'h0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  32'h4, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h4, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hC,  32'h8, 1'b1};

    model_reset();

    // Test 1: zero-wait memory, no stalls.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, vecs[i].adv, vecs[i].gnt, 1);
      chk("t1_vec", {62'h0, imem_req, imem_req ? imem_addr : 32'h0, if_id_pc, if_id_valid},
          {62'h0, vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_pc, vecs[i].exp_valid});
      chk("t1_instr", {96'h0, if_id_instr},
          {96'h0, vecs[i].exp_valid ? img(vecs[i].exp_pc) : NOP});
    end

    // Test 2: load-use stall with a response parked in the skid buffer.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1);
      chk("t2_hold_ifid", {95'h0, if_id_pc, if_id_valid}, {95'h0, 32'h4, 1'b1});
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("t2_release", {63'h0, if_id_instr, if_id_pc, if_id_valid}, {63'h0, img(32'h8), 32'h8, 1'b1});
    chk("t2_next_addr", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'hC});

    // Test 3: flush in WAIT, stale response two cycles later.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b1, 32'h100, 1'b1, 1'b0, 1);
    chk("t3_flush_ifid", {127'h0, if_id_valid}, 128'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("t3_drain_req", {126'h0, imem_req, if_id_valid}, 128'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("t3_after_drain", {94'h0, imem_req, imem_addr, if_id_valid}, {94'h0, 1'b1, 32'h100, 1'b0});
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("t3_target", {63'h0, if_id_instr, if_id_pc, if_id_valid}, {63'h0, img(32'h100), 32'h100, 1'b1});

    // Test 4: flush coincident with rvalid while stalled.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1);
    chk("t4_ifid", {63'h0, if_id_instr, if_id_pc, if_id_valid}, {63'h0, NOP, 32'h0, 1'b0});
    chk("t4_addr", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'h200});
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("t4_target", {95'h0, if_id_pc, if_id_valid}, {95'h0, 32'h200, 1'b1});

    // Test 5: unaligned redirect near the top of memory, then wrap-around.
    do_reset();
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1);
    chk("t5_aligned", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'hFFFF_FFFC});
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("t5_top", {95'h0, if_id_pc, if_id_valid}, {95'h0, 32'hFFFF_FFFC, 1'b1});
    chk("t5_wrap", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'h0});

    // Test 6: reset while holding a buffered instruction.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1);
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("t6_fresh", {63'h0, if_id_instr, if_id_pc, if_id_valid}, {63'h0, img(32'h0), 32'h0, 1'b1});

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 6, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core. Owns the PC, issues one instruction-memory request at a time, and delivers {instr, pc, valid} to decode. Sits directly upstream of the hazard detection unit and obeys its pc_write / if_id_write stall outputs. It also accepts a branch/jump flush from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or empty slot.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, synchronous, active-high.
pc_write  input  1  from hazard unit; 0 = stall PC.
if_id_write  input  1  from hazard unit; 0 = hold IF/ID register.
flush  input  1  taken branch/jump from EX; redirect fetch.
redirect_pc  input  32  target PC, valid when flush=1.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address, word aligned.
imem_gnt  input  1  memory accepts request this cycle.
imem_rvalid  input  1  response data valid.
imem_rdata  input  32  fetched instruction.
if_id_instr  output  32  instruction to decode.
if_id_pc  output  32  PC of if_id_instr.
if_id_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, state=REQ, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, skid buffer cleared. imem_req=0 while rst is high.
- Memory protocol: at most one outstanding request. The request is accepted on a cycle with imem_req&imem_gnt. Exactly one rvalid follows, at least 1 cycle later. imem_addr = pc while imem_req=1.
- advance = pc_write & if_id_write. flush has priority over the stall.
- FSM states and transitions:
  - REQ: imem_req=1.
    - flush: pc<=redirect_pc, stay REQ.
    - else gnt: go to WAIT.
  - WAIT: imem_req=0.
    - flush & rvalid: drop the response, pc<=redirect_pc, go to REQ.
    - flush & !rvalid: pc<=redirect_pc, go to DRAIN.
    - rvalid & advance: deliver rdata, pc<=pc+4, go to REQ.
    - rvalid & !advance: capture rdata in the skid buffer, go to HOLD.
  - HOLD: imem_req=0.
    - flush: discard the buffer, pc<=redirect_pc, go to REQ.
    - else advance: deliver the buffer, pc<=pc+4, go to REQ.
  - DRAIN: imem_req=0.
    - rvalid: discard the response, go to REQ.
    - flush in DRAIN: pc<=redirect_pc, stay DRAIN; a flush coincident with rvalid still goes to REQ with the new pc.
- Minimum fetch latency: gnt in cycle N, rvalid in N+1, IF/ID valid after edge N+2. Sustained throughput: one instruction per 2 cycles with zero-wait memory.
- IF/ID register update, in priority order:
  1. flush: instr=NOP_INSTR, valid=0, pc=0.
  2. !if_id_write: hold all fields.
  3. Delivery this cycle: load instr, pc of that fetch, valid=1.
  4. Otherwise: instr=NOP_INSTR, valid=0, pc held.
- PC arithmetic: 32-bit, pc+4 wraps mod 2^32 (32'hFFFF_FFFC -> 0). redirect_pc[1:0] forced to 0.
- Stall (advance=0) never blocks issuing a request in REQ. Only delivery is blocked, via HOLD.
- Stall with an undelivered response: the response is kept in HOLD for any number of stall cycles and delivered unchanged.
- If pc_write and if_id_write differ, treat as stall (advance=0). This is an illegal combination from the hazard unit; flag it with a simulation assertion.
- rst mid-operation overrides all states. A response arriving after reset for a pre-reset request is undefined; the memory model must be reset together with the core.

Decomposition:
- Shared package pipe_pkg holds:
  - fetch_state_t enum {REQ, WAIT, HOLD, DRAIN};
  - NOP_INSTR constant;
  - RESET_PC default;
  - struct if_id_t {instr, pc, valid}, also used by decode.
- One sub-module: if_id_reg. It is the IF/ID register with flush/write-enable priority, reusable by the pipeline top.
- FSM, PC and skid buffer stay in fetch_stage.

Test Plan:
1. Reset, zero-wait memory, no stalls -> imem_addr sequence 0,4,8,12. if_id_pc 0,4,8 with valid=1 every second cycle; instr matches the memory image.
2. Load-use stall: pc_write=if_id_write=0 for 3 cycles while rvalid arrives for pc=8 -> state HOLD. IF/ID holds pc=4 throughout; pc=8 is delivered on the first cycle the stall deasserts; next addr is 12.
3. flush with redirect_pc=0x100 in WAIT, rvalid 2 cycles later -> state DRAIN. The stale response is discarded and never reaches IF/ID; next imem_addr=0x100; if_id_valid=0 until 0x100 is delivered.
4. flush coincident with rvalid and with pc_write=0 -> response dropped, IF/ID becomes NOP/valid=0, next imem_addr=redirect_pc.
5. Wrap-around: redirect_pc=32'hFFFF_FFFE -> fetch at 0xFFFF_FFFC, then next address 0x0000_0000.
6. Assert rst while in HOLD with a buffered instruction -> next cycle: pc=RESET_PC, if_id_valid=0, if_id_instr=0x00000013, imem_req=0 during rst, then REQ at RESET_PC.
